// File: rtl/pattern_generator_if.sv
// Control/observation bundle between the pattern generator and its driver.
// pat_out/step/busy/done/sync are registered outputs; the rest are level inputs.
interface pattern_generator_if #(
    parameter int DIV_W = 8
);
    logic             wr_en;
    logic [2:0]       wr_addr;
    logic [3:0]       wr_data;
    logic [2:0]       length;
    logic [DIV_W-1:0] div;
    logic             loop;
    logic             start;
    logic             stop;
    logic [3:0]       pat_out;
    logic [2:0]       step;
    logic             busy;
    logic             done;
    logic             sync;

    modport master (
        output wr_en, wr_addr, wr_data, length, div, loop, start, stop,
        input  pat_out, step, busy, done, sync
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, length, div, loop, start, stop,
        output pat_out, step, busy, done, sync
    );
endinterface

// File: rtl/pattern_generator.sv
// Step-memory playback source for logic-analyzer self-test; mem[0] appears 1 cycle after start.
// No backpressure: playback free-runs, stop aborts immediately, writes are dropped while running.
module pattern_generator #(
    parameter int DEPTH = 8,
    parameter int DIV_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    pattern_generator_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_n;
    logic [3:0]       mem [DEPTH];
    logic [3:0]       pat_q, pat_n;
    logic [2:0]       step_q, step_n, step_inc;
    logic [2:0]       len_q, len_n;
    logic [DIV_W-1:0] cnt_q, cnt_n, div_q, div_n;
    logic             loop_q, loop_n;
    logic             busy_q, busy_n, done_q, done_n, sync_q, sync_n;

    assign step_inc    = step_q + 3'd1;
    assign bus.pat_out = pat_q;
    assign bus.step    = step_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.sync    = sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 4'd0;
        end else if (bus.wr_en && state == IDLE) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pat_q  <= 4'd0;
            step_q <= 3'd0;
            len_q  <= 3'd0;
            cnt_q  <= '0;
            div_q  <= '0;
            loop_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            state  <= state_n;
            pat_q  <= pat_n;
            step_q <= step_n;
            len_q  <= len_n;
            cnt_q  <= cnt_n;
            div_q  <= div_n;
            loop_q <= loop_n;
            busy_q <= busy_n;
            done_q <= done_n;
            sync_q <= sync_n;
        end
    end

    always_comb begin
        state_n = state;
        pat_n   = pat_q;
        step_n  = step_q;
        len_n   = len_q;
        cnt_n   = cnt_q;
        div_n   = div_q;
        loop_n  = loop_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        sync_n  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_n = RUN;
                    len_n   = bus.length;
                    div_n   = bus.div;
                    loop_n  = bus.loop;
                    cnt_n   = bus.div;
                    step_n  = 3'd0;
                    busy_n  = 1'b1;
                    sync_n  = 1'b1;
                    // A same-cycle write to entry 0 must be visible on the very first step.
                    pat_n   = (bus.wr_en && bus.wr_addr == 3'd0) ? bus.wr_data : mem[0];
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    pat_n   = 4'd0;
                    step_n  = 3'd0;
                end else if (cnt_q != '0) begin
                    cnt_n = cnt_q - 1'b1;
                end else if (step_q < len_q) begin
                    step_n = step_inc;
                    pat_n  = mem[step_inc];
                    cnt_n  = div_q;
                end else if (loop_q) begin
                    step_n = 3'd0;
                    pat_n  = mem[0];
                    sync_n = 1'b1;
                    cnt_n  = div_q;
                end else begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_pattern_generator.sv
// Directed vector bench for pattern_generator: table-driven cycles plus reset and max-divider sequences.
module tb_pattern_generator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    pattern_generator_if #(.DIV_W(8)) bus ();

    pattern_generator #(.DEPTH(8), .DIV_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [2:0] wa;
        logic [3:0] wd;
        logic       st;
        logic       sp;
        logic [2:0] len;
        logic [7:0] dv;
        logic       lp;
        logic [3:0] pat;
        logic [2:0] stp;
        logic       bsy;
        logic       dn;
        logic       syn;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic we, input logic [2:0] wa, input logic [3:0] wd,
                       input logic st, input logic sp, input logic [2:0] len,
                       input logic [7:0] dv, input logic lp,
                       input logic [3:0] pat, input logic [2:0] stp,
                       input logic bsy, input logic dn, input logic syn);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.st = st; v.sp = sp;
        v.len = len; v.dv = dv; v.lp = lp;
        v.pat = pat; v.stp = stp; v.bsy = bsy; v.dn = dn; v.syn = syn;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] outs();
        return {bus.pat_out, bus.step, bus.busy, bus.done, bus.sync};
    endfunction

    initial begin
        logic [3:0] d [4];
        int n;
        d[0] = 4'h3; d[1] = 4'hA; d[2] = 4'h5; d[3] = 4'hF;

        // Load and single pass, div=0.
        add(1, 0, 4'h3, 0, 0, 3, 0, 0,  4'h0, 0, 0, 0, 0);
        add(1, 1, 4'hA, 0, 0, 3, 0, 0,  4'h0, 0, 0, 0, 0);
        add(1, 2, 4'h5, 0, 0, 3, 0, 0,  4'h0, 0, 0, 0, 0);
        add(1, 3, 4'hF, 0, 0, 3, 0, 0,  4'h0, 0, 0, 0, 0);
        add(0, 0, 4'h0, 1, 0, 3, 0, 0,  4'h3, 0, 1, 0, 1);
        add(0, 0, 4'h0, 0, 0, 3, 0, 0,  4'hA, 1, 1, 0, 0);
        add(0, 0, 4'h0, 0, 0, 3, 0, 0,  4'h5, 2, 1, 0, 0);
        add(0, 0, 4'h0, 0, 0, 3, 0, 0,  4'hF, 3, 1, 0, 0);
        add(0, 0, 4'h0, 0, 0, 3, 0, 0,  4'hF, 3, 0, 1, 0);
        add(0, 0, 4'h0, 0, 0, 3, 0, 0,  4'hF, 3, 0, 0, 0);
        // Divider: each step held 3 cycles, 12 busy cycles.
        for (int s = 0; s < 4; s++)
            for (int h = 0; h < 3; h++)
                add(0, 0, 4'h0, (s == 0 && h == 0), 0, 3, 2, 0,
                    d[s], 3'(s), 1, 0, (s == 0 && h == 0));
        add(0, 0, 4'h0, 0, 0, 3, 2, 0,  4'hF, 3, 0, 1, 0);
        // Loop and stop, with an ignored write and ignored parameter changes in RUN.
        add(1, 0, 4'h1, 0, 0, 1, 0, 1,  4'hF, 3, 0, 0, 0);
        add(1, 1, 4'h2, 0, 0, 1, 0, 1,  4'hF, 3, 0, 0, 0);
        add(0, 0, 4'h0, 1, 0, 1, 0, 1,  4'h1, 0, 1, 0, 1);
        add(0, 0, 4'h0, 0, 0, 1, 0, 1,  4'h2, 1, 1, 0, 0);
        add(0, 0, 4'h0, 0, 0, 1, 0, 1,  4'h1, 0, 1, 0, 1);
        add(0, 0, 4'h0, 0, 0, 1, 0, 1,  4'h2, 1, 1, 0, 0);
        add(1, 0, 4'h7, 0, 0, 1, 0, 1,  4'h1, 0, 1, 0, 1);
        add(0, 0, 4'h0, 0, 0, 7, 9, 0,  4'h2, 1, 1, 0, 0);
        add(0, 0, 4'h0, 0, 1, 1, 0, 1,  4'h0, 0, 0, 0, 0);
        add(0, 0, 4'h0, 0, 0, 1, 0, 1,  4'h0, 0, 0, 0, 0);
        // Later pass still sees mem[0]=1.
        add(0, 0, 4'h0, 1, 0, 1, 0, 0,  4'h1, 0, 1, 0, 1);
        add(0, 0, 4'h0, 0, 0, 1, 0, 0,  4'h2, 1, 1, 0, 0);
        add(0, 0, 4'h0, 0, 0, 1, 0, 0,  4'h2, 1, 0, 1, 0);
        // Same-edge write+start forwards; length=0 single-step pass.
        add(1, 0, 4'h9, 1, 0, 0, 0, 0,  4'h9, 0, 1, 0, 1);
        add(0, 0, 4'h0, 0, 0, 0, 0, 0,  4'h9, 0, 0, 1, 0);
        // Start held across done restarts from IDLE.
        add(0, 0, 4'h0, 1, 0, 0, 0, 0,  4'h9, 0, 1, 0, 1);
        add(0, 0, 4'h0, 1, 0, 0, 0, 0,  4'h9, 0, 0, 1, 0);
        add(0, 0, 4'h0, 1, 0, 0, 0, 0,  4'h9, 0, 1, 0, 1);
        add(0, 0, 4'h0, 0, 0, 0, 0, 0,  4'h9, 0, 0, 1, 0);
        // Stop blocks start in IDLE.
        add(0, 0, 4'h0, 1, 1, 0, 0, 0,  4'h9, 0, 0, 0, 0);
        add(0, 0, 4'h0, 1, 1, 0, 0, 0,  4'h9, 0, 0, 0, 0);

        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.length = 0;
        bus.div = 0; bus.loop = 0; bus.start = 0; bus.stop = 0;
        #3;
        chk("reset_state", 32'(outs()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.wr_en = vecs[i].we; bus.wr_addr = vecs[i].wa; bus.wr_data = vecs[i].wd;
            bus.start = vecs[i].st; bus.stop = vecs[i].sp; bus.length = vecs[i].len;
            bus.div = vecs[i].dv; bus.loop = vecs[i].lp;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), 32'(outs()),
                32'({vecs[i].pat, vecs[i].stp, vecs[i].bsy, vecs[i].dn, vecs[i].syn}));
        end

        // Maximum hold: div=255 keeps a single step busy for 256 cycles.
        @(negedge clk);
        bus.wr_en = 0; bus.stop = 0; bus.start = 1; bus.length = 0; bus.div = 8'd255; bus.loop = 0;
        @(posedge clk);
        #1;
        bus.start = 0;
        n = 0;
        for (int k = 0; k < 400 && bus.busy; k++) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("max_div_busy", 32'(n), 32'd256);
        chk("max_div_done", 32'(bus.done), 32'd1);

        // Reset mid-pass clears outputs at once and wipes the memory (9,2,5,F).
        @(negedge clk);
        bus.start = 1; bus.length = 3; bus.div = 8'd2; bus.loop = 1;
        @(posedge clk);
        #1;
        bus.start = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_pat", 32'(bus.pat_out), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", 32'(outs()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.start = 1; bus.length = 3; bus.div = 8'd0; bus.loop = 0;
        for (int s = 0; s < 4; s++) begin
            @(posedge clk);
            #1;
            bus.start = 0;
            chk($sformatf("mem_clear%0d", s), 32'({bus.pat_out, bus.step, bus.busy}),
                32'({4'h0, 3'(s), 1'b1}));
        end
        @(posedge clk);
        #1;
        chk("post_rst_done", 32'({bus.busy, bus.done}), 32'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
